// File: rtl/branch_sched.sv
// rtl/branch_sched.sv - decode-stage conditional branch scheduler with hazard wait FSM and perf counters
module branch_sched #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        freeze,
  output logic        stall_d,
  output logic        resolve,
  output logic        taken,
  output logic [31:0] target,
  output logic        waiting,
  output logic        wait_err,
  output logic [31:0] br_total,
  output logic [31:0] br_taken,
  output logic [31:0] stall_cycles
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [31:0] WAIT_SAT = 32'(MAX_WAIT + 1);
  localparam logic [31:0] WAIT_MAX = 32'(MAX_WAIT);

  state_t      state;
  logic [31:0] wait_cnt;
  logic        need_rt;
  logic        ops_ok;
  logic        cond;

  // Operand readiness: only BEQ/BNE compare against rt; everything else looks at rs alone.
  always_comb begin
    need_rt = (br_type == 3'd0) || (br_type == 3'd1);
    ops_ok  = rs_ready && (rt_ready || !need_rt);
  end

  // Signed branch condition; reserved encodings never take.
  always_comb begin
    cond = 1'b0;
    case (br_type)
      3'd0:    cond = (rs_data == rt_data);
      3'd1:    cond = (rs_data != rt_data);
      3'd2:    cond = ($signed(rs_data) <= 0);
      3'd3:    cond = ($signed(rs_data) >  0);
      3'd4:    cond = ($signed(rs_data) <  0);
      3'd5:    cond = ($signed(rs_data) >= 0);
      default: cond = 1'b0;
    endcase
  end

  // Zero-latency decision outputs; the redirect target wraps modulo 2^32.
  always_comb begin
    resolve = br_valid && ops_ok && !freeze;
    taken   = resolve && cond;
    stall_d = br_valid && !ops_ok;
    waiting = (state == S_WAIT);
    target  = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  end

  // Wait FSM, sticky overflow flag and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 32'd0;
      wait_err     <= 1'b0;
      br_total     <= 32'd0;
      br_taken     <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (resolve) br_total     <= br_total + 32'd1;
      if (taken)   br_taken     <= br_taken + 32'd1;
      if (stall_d) stall_cycles <= stall_cycles + 32'd1;

      case (state)
        S_IDLE: begin
          if (br_valid && !ops_ok) begin
            state    <= S_WAIT;
            wait_cnt <= 32'd1;
            if (WAIT_MAX < 32'd1) wait_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!br_valid) begin
            // D was flushed underneath us: drop the branch without resolving it.
            state    <= S_IDLE;
            wait_cnt <= 32'd0;
          end else if (ops_ok) begin
            // Ready but frozen holds both state and count.
            if (!freeze) begin
              state    <= S_IDLE;
              wait_cnt <= 32'd0;
            end
          end else begin
            if (wait_cnt < WAIT_SAT) wait_cnt <= wait_cnt + 32'd1;
            if (wait_cnt >= WAIT_MAX) wait_err <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sched.sv
// tb/tb_branch_sched.sv - directed self-checking bench for branch_sched
module tb_branch_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_type;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_ready;
  logic        rt_ready;
  logic        freeze;
  logic        stall_d;
  logic        resolve;
  logic        taken;
  logic [31:0] target;
  logic        waiting;
  logic        wait_err;
  logic [31:0] br_total;
  logic [31:0] br_taken;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  branch_sched #(.MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
    .pc_d(pc_d), .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .freeze(freeze),
    .stall_d(stall_d), .resolve(resolve), .taken(taken), .target(target),
    .waiting(waiting), .wait_err(wait_err), .br_total(br_total),
    .br_taken(br_taken), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr, input logic frz);
    br_valid = 1'b1; br_type = t; pc_d = pc; imm16 = imm;
    rs_data = rs; rt_data = rt; rs_ready = rsr; rt_ready = rtr; freeze = frz;
  endtask

  task automatic idle();
    br_valid = 1'b0; br_type = 3'd0; pc_d = 32'd0; imm16 = 16'd0;
    rs_data = 32'd0; rt_data = 32'd0; rs_ready = 1'b0; rt_ready = 1'b0; freeze = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic counters(input string tag, input logic [31:0] t, input logic [31:0] k, input logic [31:0] s);
    check({tag, "_total"}, br_total, t);
    check({tag, "_taken"}, br_taken, k);
    check({tag, "_stall"}, stall_cycles, s);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_stall", stall_d, 0);
    check("rst_resolve", resolve, 0);
    check("rst_taken", taken, 0);
    check("rst_waiting", waiting, 0);
    check("rst_err", wait_err, 0);
    counters("rst", 0, 0, 0);
    step();

    // BEQ taken, both operands ready
    drive(3'd0, 32'h0000_3000, 16'h0004, 32'h10, 32'h10, 1, 1, 0);
    @(negedge clk);
    check("beq_resolve", resolve, 1);
    check("beq_taken", taken, 1);
    check("beq_target", target, 32'h0000_3014);
    check("beq_stall", stall_d, 0);
    step();
    idle();
    @(negedge clk);
    counters("beq", 1, 1, 0);
    step();

    // Signed single-operand conditions
    drive(3'd3, 32'h100, 16'h0, 32'h8000_0000, 32'h0, 1, 0, 0);
    @(negedge clk);
    check("bgtz_resolve", resolve, 1);
    check("bgtz_taken", taken, 0);
    step();
    drive(3'd2, 32'h104, 16'h0, 32'h8000_0000, 32'h0, 1, 0, 0);
    @(negedge clk);
    check("blez_taken", taken, 1);
    step();
    drive(3'd5, 32'h108, 16'h0, 32'h0, 32'h0, 1, 0, 0);
    @(negedge clk);
    check("bgez_taken", taken, 1);
    step();
    drive(3'd4, 32'h10c, 16'h0, 32'h0, 32'h0, 1, 0, 0);
    @(negedge clk);
    check("bltz_resolve", resolve, 1);
    check("bltz_taken", taken, 0);
    step();
    idle();
    @(negedge clk);
    counters("sgn", 5, 3, 0);
    step();

    // BNE waits two cycles on rt
    drive(3'd1, 32'h200, 16'h1, 32'd5, 32'd6, 1, 0, 0);
    @(negedge clk);
    check("bne_c1_stall", stall_d, 1);
    check("bne_c1_resolve", resolve, 0);
    step();
    @(negedge clk);
    check("bne_c2_stall", stall_d, 1);
    check("bne_c2_waiting", waiting, 1);
    step();
    rt_ready = 1'b1;
    @(negedge clk);
    check("bne_c3_waiting", waiting, 1);
    check("bne_c3_resolve", resolve, 1);
    check("bne_c3_taken", taken, 1);
    check("bne_c3_stall", stall_d, 0);
    step();
    idle();
    @(negedge clk);
    check("bne_waiting_after", waiting, 0);
    check("bne_err", wait_err, 0);
    counters("bne", 6, 4, 2);
    step();

    // Target wrap and reserved type
    drive(3'd0, 32'h0, 16'h8000, 32'd1, 32'd1, 1, 1, 0);
    @(negedge clk);
    check("wrap_target", target, 32'hFFFE_0004);
    check("wrap_taken", taken, 1);
    step();
    drive(3'd7, 32'h300, 16'h0, 32'd0, 32'd0, 1, 1, 0);
    @(negedge clk);
    check("rsvd_resolve", resolve, 1);
    check("rsvd_taken", taken, 0);
    step();
    idle();
    @(negedge clk);
    counters("rsvd", 8, 5, 2);
    step();

    // Long wait: rs not ready for 5 cycles trips wait_err after the 4th
    drive(3'd4, 32'h400, 16'h0, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("long_c%0d_stall", i), stall_d, 1);
      check($sformatf("long_c%0d_err", i), wait_err, (i >= 5) ? 32'd1 : 32'd0);
      step();
    end
    rs_ready = 1'b1;
    @(negedge clk);
    check("long_resolve", resolve, 1);
    check("long_taken", taken, 1);
    step();
    idle();
    @(negedge clk);
    check("long_err_sticky", wait_err, 1);
    check("long_waiting", waiting, 0);
    counters("long", 9, 6, 7);
    step();

    // Reset while waiting abandons the branch
    drive(3'd0, 32'h500, 16'h0, 32'd1, 32'd1, 1, 0, 0);
    step();
    @(negedge clk);
    check("rw_waiting", waiting, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check("rw_waiting_after", waiting, 0);
    check("rw_err", wait_err, 0);
    counters("rw", 0, 0, 0);
    step();

    // Freeze with ready operands: no resolve, no stall, until freeze drops
    drive(3'd0, 32'h600, 16'h2, 32'd3, 32'd3, 1, 1, 1);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check($sformatf("frz_c%0d_resolve", i), resolve, 0);
      check($sformatf("frz_c%0d_stall", i), stall_d, 0);
      check($sformatf("frz_c%0d_waiting", i), waiting, 0);
      step();
    end
    freeze = 1'b0;
    @(negedge clk);
    check("frz_resolve", resolve, 1);
    check("frz_taken", taken, 1);
    check("frz_target", target, 32'h0000_060C);
    step();
    idle();
    @(negedge clk);
    counters("frz", 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_sched.md
# branch_sched

Decode-stage branch scheduler for the five-stage MIPS pipeline. It holds a conditional branch in D until both source operands are forwardable, evaluates the signed condition, and drives the fetch redirect in the resolve cycle. It also keeps performance counters and flags a branch that waits longer than the hazard model permits.

## Interface

Parameters:
- MAX_WAIT, 3: wait cycles after which `wait_err` sets.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- br_valid  in  1  conditional branch present in D.
- br_type  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; 6/7 reserved.
- pc_d  in  32  address of the branch.
- imm16  in  16  branch offset field.
- rs_data, rt_data  in  32  forwarded operand values.
- rs_ready, rt_ready  in  1  operand value is final this cycle (from hazard unit).
- freeze  in  1  D held by another stall source.
- stall_d  out  1  hold F/D because of this branch.
- resolve  out  1  branch decided this cycle.
- taken  out  1  redirect fetch this cycle.
- target  out  32  pc_d + 4 + (sext(imm16) << 2).
- waiting  out  1  FSM in WAIT.
- wait_err  out  1  sticky overflow flag.
- br_total, br_taken, stall_cycles  out  32  performance counters.

## Operation

- Operand need: BEQ and BNE need rs and rt. Types 2–5 need rs only and ignore `rt_ready`.
- ops_ok = all needed ready bits are high.
- Conditions are combinational, all signed two's complement:
  - BEQ: rs == rt. BNE: rs != rt.
  - BLEZ: rs <= 0. BGTZ: rs > 0. BLTZ: rs < 0. BGEZ: rs >= 0.
  - Reserved types: condition is 0 and resolve proceeds as not taken.
- `target` uses 32-bit modular arithmetic, so it wraps at 2^32. `target` is driven every cycle and is meaningful only when `taken` = 1.
- FSM has two states: IDLE and WAIT.
  - IDLE: if br_valid & !ops_ok, go to WAIT and clear wait_cnt to 1.
  - IDLE: if br_valid & ops_ok & !freeze, resolve this cycle and stay in IDLE.
  - WAIT: if ops_ok & !freeze, resolve and go to IDLE. Otherwise stay and increment wait_cnt, saturating at MAX_WAIT+1.
  - WAIT: if br_valid drops (D flushed), go to IDLE without resolving.
- resolve = br_valid & ops_ok & !freeze, evaluated in the current state.
- taken = resolve & cond.
- stall_d = br_valid & !ops_ok. It is independent of `freeze`.
- waiting = (state == WAIT).
- wait_err sets when wait_cnt would exceed MAX_WAIT. It stays set until reset; the FSM keeps waiting.
- Counters wrap modulo 2^32:
  - br_total increments on each resolve.
  - br_taken increments on each taken.
  - stall_cycles increments on each cycle with stall_d = 1.

## Timing

- Reset takes effect on a clk edge with reset = 1. After that edge:
  - state is IDLE and wait_cnt = 0.
  - wait_err = 0 and all counters = 0.
  - With br_valid = 0: stall_d = resolve = taken = waiting = 0.
- Reset during WAIT abandons the branch. The counters do not count it.
- Decision latency is 0 cycles from ops_ok:
  - `resolve`, `taken` and `target` are combinational in the cycle ops_ok rises, provided freeze = 0.
  - The PC register captures `target` at that edge. The delay slot, already in F, proceeds normally.
- Each branch resolves exactly once. The pipeline advances D on the resolve edge, so the next br_valid belongs to a new instruction.
- ops_ok & freeze: no resolve and no stall_d. The state is held (IDLE stays IDLE; WAIT stays WAIT with wait_cnt held).
- Counter updates and wait_err are registered. They are visible the cycle after the qualifying event.

## Test plan

- BEQ with rs = rt = 0x0000_0010, both ready, pc_d = 0x0000_3000, imm16 = 0x0004 -> same cycle: resolve = 1, taken = 1, target = 0x0000_3014, stall_d = 0. Next cycle: br_total = 1, br_taken = 1.
- BGTZ with rs = 0x8000_0000 (negative), ready -> resolve = 1, taken = 0. Repeat with BLEZ -> taken = 1. BGEZ with rs = 0 -> taken = 1. BLTZ with rs = 0 -> taken = 0.
- BNE with rt_ready low for 2 cycles, rs = 5, rt = 6 -> stall_d = 1 and waiting = 1 for 2 cycles. Third cycle: resolve = 1, taken = 1. stall_cycles = 2; wait_err = 0.
- imm16 = 0x8000 with pc_d = 0x0000_0000 -> target = 0xFFFE_0004 (wrap). Reserved br_type = 7 -> resolve = 1, taken = 0.
- rs_ready held low for 5 cycles with MAX_WAIT = 3 -> wait_err goes to 1 after the 4th wait cycle and stays 1 after rs_ready rises and the branch resolves.
- Reset asserted in WAIT -> next cycle: waiting = 0 and all counters 0. br_valid with freeze = 1 and ops_ok = 1 -> resolve = 0 and stall_d = 0 until freeze drops.
